// File: rtl/riscv_mul_ctrl.sv
// riscv_mul_ctrl
// Execute-stage sequencer around the combinational riscv_multiplier.
// Captures RV64M multiply operands on an accepted start, holds them stable on the
// multiplier inputs for MUL_CYCLES cycles, registers the product (with MULW sign
// extension) and presents it to writeback as a level-valid result.
//
// Ports
//   i_riscv_mulctl_clk       clock, rising edge
//   i_riscv_mulctl_rst_n     synchronous active-low reset
//   i_riscv_mulctl_start     one-cycle request from execute
//   i_riscv_mulctl_mulctrl   100 MUL, 101 MULH, 110 MULHU, 111 MULHSU
//   i_riscv_mulctl_word      MULW (only with MUL)
//   i_riscv_mulctl_rs1data   operand 1
//   i_riscv_mulctl_rs2data   operand 2
//   i_riscv_mulctl_rdaddr    destination tag
//   i_riscv_mulctl_flush     kill in-flight operation
//   i_riscv_mulctl_stall     downstream not ready for the result
//   o_riscv_mulctl_busy      stall request to the hazard unit
//   o_riscv_mulctl_valid     result valid
//   o_riscv_mulctl_result    final result
//   o_riscv_mulctl_rdaddr    tag of the result
//   o_riscv_mulctl_mul_rs1   multiplier operand 1
//   o_riscv_mulctl_mul_rs2   multiplier operand 2
//   o_riscv_mulctl_mul_ctrl  multiplier control
//   i_riscv_mulctl_mul_prod  multiplier product

module riscv_mul_ctrl #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic            i_riscv_mulctl_clk,
    input  logic            i_riscv_mulctl_rst_n,
    input  logic            i_riscv_mulctl_start,
    input  logic [2:0]      i_riscv_mulctl_mulctrl,
    input  logic            i_riscv_mulctl_word,
    input  logic [XLEN-1:0] i_riscv_mulctl_rs1data,
    input  logic [XLEN-1:0] i_riscv_mulctl_rs2data,
    input  logic [4:0]      i_riscv_mulctl_rdaddr,
    input  logic            i_riscv_mulctl_flush,
    input  logic            i_riscv_mulctl_stall,
    output logic            o_riscv_mulctl_busy,
    output logic            o_riscv_mulctl_valid,
    output logic [XLEN-1:0] o_riscv_mulctl_result,
    output logic [4:0]      o_riscv_mulctl_rdaddr,
    output logic [XLEN-1:0] o_riscv_mulctl_mul_rs1,
    output logic [XLEN-1:0] o_riscv_mulctl_mul_rs2,
    output logic [2:0]      o_riscv_mulctl_mul_ctrl,
    input  logic [XLEN-1:0] i_riscv_mulctl_mul_prod
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic [2:0]        r_ctrl;
    logic              r_word;
    logic [4:0]        r_rdaddr;
    logic [XLEN-1:0]   r_result;
    logic              w_accept;
    logic              w_load_result;
    logic [XLEN-1:0]   w_result_next;

    // Only multiply codes (mulctrl[2]=1) are ours; a flush in the same cycle wins.
    assign w_accept = (r_state == StIdle) && i_riscv_mulctl_start &&
                      i_riscv_mulctl_mulctrl[2] && !i_riscv_mulctl_flush;

    // Low 32 product bits are the same for every variant, so MULW only needs extension here.
    assign w_result_next = r_word ?
        {{(XLEN-32){i_riscv_mulctl_mul_prod[31]}}, i_riscv_mulctl_mul_prod[31:0]} :
        i_riscv_mulctl_mul_prod;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_load_result = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StCalc;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            StCalc: begin
                if (r_cnt == '0) begin
                    w_load_result = 1'b1;
                    w_state_next  = StDone;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            StDone: begin
                if (!i_riscv_mulctl_stall) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
        if (i_riscv_mulctl_flush) begin
            w_state_next  = StIdle;
            w_cnt_next    = '0;
            w_load_result = 1'b0;
        end
    end

    always_ff @(posedge i_riscv_mulctl_clk) begin
        if (!i_riscv_mulctl_rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_ctrl   <= 3'b000;
            r_word   <= 1'b0;
            r_rdaddr <= 5'd0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_rs1    <= i_riscv_mulctl_rs1data;
                r_rs2    <= i_riscv_mulctl_rs2data;
                r_ctrl   <= i_riscv_mulctl_mulctrl;
                r_word   <= i_riscv_mulctl_word;
                r_rdaddr <= i_riscv_mulctl_rdaddr;
            end
            if (w_load_result) begin
                r_result <= w_result_next;
            end
        end
    end

    assign o_riscv_mulctl_busy     = w_accept || (r_state == StCalc);
    assign o_riscv_mulctl_valid    = (r_state == StDone);
    assign o_riscv_mulctl_result   = r_result;
    assign o_riscv_mulctl_rdaddr   = r_rdaddr;
    // Multiplier inputs come only from captured registers so the multicycle path stays stable.
    assign o_riscv_mulctl_mul_rs1  = r_rs1;
    assign o_riscv_mulctl_mul_rs2  = r_rs2;
    assign o_riscv_mulctl_mul_ctrl = r_ctrl;

endmodule

// File: tb/tb_riscv_mul_ctrl.sv
module tb_riscv_mul_ctrl;

    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  mulctrl;
    logic        word;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [4:0]  rdaddr;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        valid;
    logic [63:0] result;
    logic [4:0]  rdaddr_o;
    logic [63:0] mul_rs1;
    logic [63:0] mul_rs2;
    logic [2:0]  mul_ctrl;
    logic [63:0] mul_prod;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_mul_ctrl #(
        .XLEN       (64),
        .MUL_CYCLES (MC)
    ) dut (
        .i_riscv_mulctl_clk      (clk),
        .i_riscv_mulctl_rst_n    (rst_n),
        .i_riscv_mulctl_start    (start),
        .i_riscv_mulctl_mulctrl  (mulctrl),
        .i_riscv_mulctl_word     (word),
        .i_riscv_mulctl_rs1data  (rs1),
        .i_riscv_mulctl_rs2data  (rs2),
        .i_riscv_mulctl_rdaddr   (rdaddr),
        .i_riscv_mulctl_flush    (flush),
        .i_riscv_mulctl_stall    (stall),
        .o_riscv_mulctl_busy     (busy),
        .o_riscv_mulctl_valid    (valid),
        .o_riscv_mulctl_result   (result),
        .o_riscv_mulctl_rdaddr   (rdaddr_o),
        .o_riscv_mulctl_mul_rs1  (mul_rs1),
        .o_riscv_mulctl_mul_rs2  (mul_rs2),
        .o_riscv_mulctl_mul_ctrl (mul_ctrl),
        .i_riscv_mulctl_mul_prod (mul_prod)
    );

    // Combinational multiplier stand-in: signed-extended 130-bit product.
    logic signed [129:0] ea, eb, ep;
    always_comb begin
        ea = (mul_ctrl == 3'b101 || mul_ctrl == 3'b111) ?
             signed'({{66{mul_rs1[63]}}, mul_rs1}) : signed'({66'd0, mul_rs1});
        eb = (mul_ctrl == 3'b101) ?
             signed'({{66{mul_rs2[63]}}, mul_rs2}) : signed'({66'd0, mul_rs2});
        ep = ea * eb;
        if (mul_ctrl == 3'b100)   mul_prod = ep[63:0];
        else if (mul_ctrl[2])     mul_prod = ep[127:64];
        else                      mul_prod = 64'd0;
    end

    // Reference: unsigned product with sign corrections for the high half.
    function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                               input logic [2:0] c, input logic w);
        logic [127:0] pu;
        logic [63:0]  hi;
        pu = {64'd0, a} * {64'd0, b};
        hi = pu[127:64];
        case (c)
            3'b100:  return w ? {{32{pu[31]}}, pu[31:0]} : pu[63:0];
            3'b101:  return hi - (a[63] ? b : 64'd0) - (b[63] ? a : 64'd0);
            3'b110:  return hi;
            3'b111:  return hi - (a[63] ? b : 64'd0);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'd0;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_valid"}, 64'(valid), 64'd0);
        check({tag, "_result"}, result, 64'd0);
        check({tag, "_rdaddr"}, 64'(rdaddr_o), 64'd0);
        check({tag, "_mrs1"}, mul_rs1, 64'd0);
        check({tag, "_mrs2"}, mul_rs2, 64'd0);
        check({tag, "_mctrl"}, 64'(mul_ctrl), 64'd0);
    endtask

    // Full operation starting in the current cycle (cycle 0); ends one cycle after the last valid.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] c,
                          input logic w, input logic [4:0] rd, input int nstall,
                          input bit noise);
        logic [63:0] exp;
        exp = ref_result(a, b, c, w);
        start = 1'b1; mulctrl = c; word = w; rs1 = a; rs2 = b; rdaddr = rd;
        flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("c0_busy", 64'(busy), 64'd1);
        check("c0_valid", 64'(valid), 64'd0);
        next_cycle();
        for (int i = 1; i <= MC; i++) begin
            start = noise; mulctrl = 3'b100; word = 1'b0;
            rs1 = rnd64(); rs2 = rnd64(); rdaddr = 5'($urandom);
            @(negedge clk);
            check("calc_busy", 64'(busy), 64'd1);
            check("calc_valid", 64'(valid), 64'd0);
            check("calc_mrs1", mul_rs1, a);
            check("calc_mrs2", mul_rs2, b);
            check("calc_mctrl", 64'(mul_ctrl), 64'(c));
            next_cycle();
        end
        for (int k = 0; k <= nstall; k++) begin
            stall = (k < nstall);
            start = noise;
            rs1 = rnd64(); rs2 = rnd64(); rdaddr = 5'($urandom);
            @(negedge clk);
            check("done_valid", 64'(valid), 64'd1);
            check("done_result", result, exp);
            check("done_rdaddr", 64'(rdaddr_o), 64'(rd));
            check("done_busy", 64'(busy), 64'd0);
            next_cycle();
        end
        start = 1'b0; stall = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mulctrl = 3'b000; word = 1'b0;
        rs1 = 64'd0; rs2 = 64'd0; rdaddr = 5'd0; flush = 1'b0; stall = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        next_cycle();

        // Directed cases
        run_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 3'b100, 1'b0, 5'd7, 0, 1'b0);
        @(negedge clk);
        check("after_valid", 64'(valid), 64'd0);
        next_cycle();
        run_op('1, '1, 3'b101, 1'b0, 5'd1, 0, 1'b0);
        run_op('1, '1, 3'b110, 1'b0, 5'd2, 0, 1'b0);   // back-to-back accept
        run_op('1, 64'd2, 3'b111, 1'b0, 5'd3, 0, 1'b0);
        run_op(64'h0000_0000_8000_0000, 64'd1, 3'b100, 1'b1, 5'd4, 0, 1'b0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 3'b110, 1'b0, 5'd5, 3, 1'b1);

        // Flush in cycle 1 of CALC
        start = 1'b1; mulctrl = 3'b100; rs1 = 64'd7; rs2 = 64'd9; rdaddr = 5'd9;
        next_cycle();
        start = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_c1_busy", 64'(busy), 64'd1);
        next_cycle();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("flush_busy", 64'(busy), 64'd0);
            check("flush_valid", 64'(valid), 64'd0);
            next_cycle();
        end
        run_op(64'd7, 64'd9, 3'b100, 1'b0, 5'd9, 0, 1'b0);

        // Start together with flush is not accepted
        start = 1'b1; flush = 1'b1; mulctrl = 3'b101;
        @(negedge clk);
        check("sflush_busy", 64'(busy), 64'd0);
        next_cycle();
        start = 1'b0; flush = 1'b0;
        for (int i = 0; i < MC + 2; i++) begin
            @(negedge clk);
            check("sflush_valid", 64'(valid), 64'd0);
            check("sflush_busy2", 64'(busy), 64'd0);
            next_cycle();
        end

        // Reset mid-CALC, then an ignored non-multiply start
        start = 1'b1; mulctrl = 3'b111; rs1 = 64'd11; rs2 = 64'd13; rdaddr = 5'd17;
        next_cycle();
        start = 1'b0; rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        next_cycle();
        start = 1'b1; mulctrl = 3'b010;
        @(negedge clk);
        check("ign_busy", 64'(busy), 64'd0);
        check("ign_valid", 64'(valid), 64'd0);
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < MC + 2; i++) begin
            @(negedge clk);
            check("ign_valid2", 64'(valid), 64'd0);
            check("ign_busy2", 64'(busy), 64'd0);
            next_cycle();
        end

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            logic [2:0] c;
            logic       w;
            c = {1'b1, 2'($urandom)};
            w = (c == 3'b100) ? 1'($urandom) : 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; mulctrl = {1'b0, 2'($urandom)};
                @(negedge clk);
                check("rnd_ign_busy", 64'(busy), 64'd0);
                next_cycle();
            end
            run_op(rnd64(), rnd64(), c, w, 5'($urandom), $urandom_range(0, 2),
                   1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
